// File: rtl/pipeline_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central sequencer for the 5-stage core. It merges the decode
//               and execute stall requests and runs multi-cycle execute ops
//               (div, madd/msub) through a small FSM with a down-counter.
//               It produces the per-stage stall vector and the NOP bubble
//               strobes. An exception flush overrides everything.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int MC_CNT_W    = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_from_id,
    input  logic                   stallreq_from_ex,
    input  logic                   ex_mc_start,
    input  logic [MC_CNT_W-1:0]    ex_mc_cycles,
    input  logic                   flush_req,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic                   ex_mem_bubble,
    output logic                   id_ex_bubble,
    output logic                   mc_busy,
    output logic                   mc_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Stall patterns: bit0=pc, bit1=if, bit2=id, bit3=ex, bit4=mem, bit5=wb
    localparam logic [5:0] c_STALL_NONE = 6'b000000;
    localparam logic [5:0] c_STALL_EX   = 6'b001111;
    localparam logic [5:0] c_STALL_ID   = 6'b000111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [MC_CNT_W-1:0]    r_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic [MC_CNT_W-1:0]    w_mc_len;
    logic                   w_mc_stall;
    logic [5:0]             w_stall;

    // A zero-length op behaves exactly like a single-cycle op.
    assign w_mc_len = (ex_mc_cycles == '0) ? MC_CNT_W'(1) : ex_mc_cycles;

    // The start cycle itself stalls, so an N-cycle op stalls for N cycles in total.
    assign w_mc_stall = ((r_state == S_IDLE) && ex_mc_start) || (r_state == S_BUSY);

    // Stall vector with priority flush > EX-level stall > ID-level stall.
    always_comb begin
        w_stall = c_STALL_NONE;
        if (rst || flush_req) begin
            w_stall = c_STALL_NONE;
        end else if (w_mc_stall || stallreq_from_ex) begin
            w_stall = c_STALL_EX;
        end else if (stallreq_from_id) begin
            w_stall = c_STALL_ID;
        end
    end

    assign stall         = w_stall;
    assign flush         = flush_req & ~rst;
    // A stage inserts a NOP when it is held but the stage downstream keeps moving.
    assign ex_mem_bubble = w_stall[3] & ~w_stall[4];
    assign id_ex_bubble  = w_stall[2] & ~w_stall[3];
    assign mc_busy       = ~rst & (r_state != S_IDLE);
    // A flush in the DONE cycle kills the writeback of the multi-cycle result.
    assign mc_done       = ~rst & ~flush_req & (r_state == S_DONE);
    assign stall_cycles  = r_stall_cycles;

    // Multi-cycle sequencer: IDLE -> (BUSY) -> DONE -> IDLE, aborted by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (flush_req) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ex_mc_start) begin
                        if (w_mc_len >= MC_CNT_W'(2)) begin
                            r_cnt   <= w_mc_len - MC_CNT_W'(1);
                            r_state <= S_BUSY;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    // cnt==0 cannot occur by construction; treat it as the last cycle.
                    if (r_cnt <= MC_CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - MC_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating statistics counter of cycles where any stage was stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if ((w_stall != c_STALL_NONE) && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. A reference model that
//               tracks remaining op cycles feeds a scoreboard queue. A monitor
//               pops one entry per cycle and compares it with the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_from_id = 1'b0;
    logic        stallreq_from_ex = 1'b0;
    logic        ex_mc_start = 1'b0;
    logic [5:0]  ex_mc_cycles = 6'd0;
    logic        flush_req = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_mem_bubble;
    logic        id_ex_bubble;
    logic        mc_busy;
    logic        mc_done;
    logic [15:0] stall_cycles;

    pipeline_ctrl #(.MC_CNT_W(6), .STALL_CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (stallreq_from_id),
        .stallreq_from_ex (stallreq_from_ex),
        .ex_mc_start      (ex_mc_start),
        .ex_mc_cycles     (ex_mc_cycles),
        .flush_req        (flush_req),
        .stall            (stall),
        .flush            (flush),
        .ex_mem_bubble    (ex_mem_bubble),
        .id_ex_bubble     (id_ex_bubble),
        .mc_busy          (mc_busy),
        .mc_done          (mc_done),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        emb;
        logic        ieb;
        logic        busy;
        logic        done;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: number of BUSY cycles still to come, whether the next
    // cycle is the DONE cycle, and the saturating stall statistic.
    int   m_busy_left = 0;
    bit   m_in_done   = 1'b0;
    int   m_count     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of stimulus, queue the expected outputs, advance the model.
    task automatic step(input bit r, input bit id, input bit ex, input bit st,
                        input int cyc, input bit fl);
        exp_t e;
        bit   idle;
        bit   mcs;
        int   n;
        rst = r; stallreq_from_id = id; stallreq_from_ex = ex;
        ex_mc_start = st; ex_mc_cycles = 6'(cyc); flush_req = fl;
        idle = (m_busy_left == 0) && !m_in_done;
        mcs  = (idle && st) || (m_busy_left > 0);
        if (r)             e.stall = 6'b000000;
        else if (fl)       e.stall = 6'b000000;
        else if (mcs || ex) e.stall = 6'b001111;
        else if (id)       e.stall = 6'b000111;
        else               e.stall = 6'b000000;
        e.flush = fl && !r;
        e.emb   = e.stall == 6'b001111;
        e.ieb   = e.stall == 6'b000111;
        e.busy  = !r && !idle;
        e.done  = !r && !fl && m_in_done;
        e.sc    = 16'(m_count);
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            m_count = 0;
        end else if (e.stall != 6'b0 && m_count < 65535) begin
            m_count = m_count + 1;
        end
        if (r || fl) begin
            m_busy_left = 0;
            m_in_done   = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left = m_busy_left - 1;
            m_in_done   = (m_busy_left == 0);
        end else if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (st) begin
            n = (cyc == 0) ? 1 : cyc;
            m_busy_left = n - 1;
            m_in_done   = (n == 1);
        end
        #1;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall",         32'(stall),         32'(e.stall));
            chk("flush",         32'(flush),         32'(e.flush));
            chk("ex_mem_bubble", 32'(ex_mem_bubble), 32'(e.emb));
            chk("id_ex_bubble",  32'(id_ex_bubble),  32'(e.ieb));
            chk("mc_busy",       32'(mc_busy),       32'(e.busy));
            chk("mc_done",       32'(mc_done),       32'(e.done));
            chk("stall_cycles",  32'(stall_cycles),  32'(e.sc));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // First edge clears the unknown register contents; nothing checked yet.
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        idle_cycles(10);

        // Load-use stall for 3 cycles.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        idle_cycles(2);

        // N=5 op with start held high throughout.
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 5, 0);
        idle_cycles(2);

        // N=0 and N=1 both give a single stall cycle.
        step(0, 0, 0, 1, 0, 0); idle_cycles(3);
        step(0, 0, 0, 1, 1, 0); idle_cycles(3);

        // Flush in the 3rd BUSY cycle of an N=8 op.
        step(0, 0, 0, 1, 8, 0);
        step(0, 0, 0, 0, 8, 0);
        step(0, 0, 0, 0, 8, 0);
        step(0, 0, 0, 1, 8, 1);
        idle_cycles(12);

        // Flush in the DONE cycle of an N=2 op.
        step(0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 2, 1);
        idle_cycles(2);

        // Both stall requests together, then reset in the middle of an op.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 9, 0);
        step(1, 1, 0, 0, 9, 0);
        idle_cycles(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, id, ex, st, fl;
            int cyc;
            r   = ($urandom_range(0, 199) == 0);
            id  = ($urandom_range(0, 3) == 0);
            ex  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 5) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            cyc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63))
                                               : int'($urandom_range(0, 6));
            step(r, id, ex, st, cyc, fl);
        end

        // Saturation: 65540 stalled cycles from a clean counter.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 0, 1, 0, 0, 0);
        idle_cycles(3);
        chk("stall_cycles_saturated", 32'(stall_cycles), 32'hFFFF);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges stall requests from the decode and execute stages, sequences multi-cycle execute operations (div, madd/msub through HI/LO) with an internal FSM and down-counter, and produces the per-stage stall vector and bubble strobes. The EX/MEM and ID/EX pipeline registers use the bubble strobes to load NOP contents. Exception flush overrides everything.

Parameters:
MC_CNT_W, 6, width of the multi-cycle length field (max 63 cycles)
STALL_CNT_W, 16, width of the saturating stall-cycle statistics counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high (`RstEnable`)
stallreq_from_id  in  1  decode-stage stall request (load-use hazard)
stallreq_from_ex  in  1  execute-stage single-cycle stall request
ex_mc_start  in  1  EX holds a multi-cycle op; sampled only in IDLE
ex_mc_cycles  in  MC_CNT_W  op length N in cycles; 0 is treated as 1
flush_req  in  1  exception or flush request from the MEM stage
stall  out  6  stall[0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb
flush  out  1  flush to all pipeline registers
ex_mem_bubble  out  1  EX/MEM loads NOP (stall[3] & ~stall[4])
id_ex_bubble  out  1  ID/EX loads NOP (stall[2] & ~stall[3])
mc_busy  out  1  FSM is not in IDLE
mc_done  out  1  one-cycle strobe: EX result/HI-LO may be written this cycle
stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall != 0

Behaviour:
- Reset (sync, rst=1): state=IDLE, cnt=0, stall_cycles=0. All outputs evaluate to 0, including stall, flush, bubbles, mc_busy and mc_done.
- FSM states:
  - IDLE: if ex_mc_start and no flush_req, load cnt=N-1 and go to BUSY when N>=2. When N<=1, go directly to DONE.
  - BUSY: if cnt==1, go to DONE; otherwise decrement cnt.
  - DONE: go to IDLE unconditionally. mc_done=1 only in this state.
- Stall timing:
  - The start cycle in IDLE plus all BUSY cycles assert the multi-cycle stall.
  - An op of length N therefore produces exactly N stalled cycles, then one DONE cycle with the stall released.
  - N=0 and N=1 each produce 1 stall cycle.
- The multi-cycle stall is combinational: mc_stall = (IDLE & ex_mc_start) | BUSY.
- ex_mc_start is ignored while in BUSY or DONE. A new op may start in the cycle after DONE.
- Stall vector (combinational, priority order):
  - flush_req=1: stall=000000.
  - else mc_stall | stallreq_from_ex: stall=001111.
  - else stallreq_from_id: stall=000111.
  - else stall=000000.
- flush = flush_req (combinational).
- A flush_req in any state forces next state IDLE and cnt=0. mc_done is suppressed in that cycle even if the state is DONE. A simultaneous ex_mc_start is dropped.
- Bubbles are derived from stall, giving:
  - ex_mem_bubble=1 with an EX-level stall.
  - id_ex_bubble=1 with an ID-level stall.
  - Both are 0 during flush.
- stall_cycles increments when stall!=0 and saturates at all-ones. It is cleared only by rst.
- A reset asserted in the middle of an op aborts it. There is no mc_done and the FSM is in IDLE on the next cycle.

Test Plan:
- Reset, then idle inputs -> stall=000000, flush=0, mc_busy=0, stall_cycles=0 for 10 cycles.
- stallreq_from_id=1 for 3 cycles -> stall=000111 and id_ex_bubble=1 for those 3 cycles, ex_mem_bubble=0, stall_cycles=3.
- ex_mc_start=1 with ex_mc_cycles=5 (held) -> stall=001111 and ex_mem_bubble=1 in cycles 0-4. mc_busy=1 in cycles 1-5. mc_done=1 in cycle 5 only with stall=000000. IDLE in cycle 6.
- ex_mc_cycles=0 and ex_mc_cycles=1 -> each gives 1 stall cycle followed by an mc_done pulse on the next cycle.
- flush_req in the 3rd BUSY cycle of an N=8 op -> stall=000000 and flush=1 that cycle, IDLE next cycle, mc_done never asserted. A flush_req in the DONE cycle -> mc_done=0.
- stallreq_from_id and stallreq_from_ex together -> stall=001111. Force 65540 stalled cycles -> stall_cycles=0xFFFF and holds.
